edge_overlay_key: RTL and testbench

Parametrised edge-overlay keyer that sits between the edge-detector output and the pixel mux feeding the display. Per pixel it decides whether the edge map overrides the camera video, driving `select` low to choose the overlay. Decisions use one of four keying modes: exact, threshold, threshold with horizontal dilation, or inverted threshold. It outputs an overlay pixel that is either a grey replication of the edge value across all channels or a fixed colour, and counts overlay pixels per frame. The path is a two-stage pipeline qualified by a valid strobe.

---
 rtl/edge_overlay_key_if.sv | 30 +++
 rtl/edge_overlay_key.sv | 145 ++++++++++++++
 tb/tb_edge_overlay_key.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/edge_overlay_key_if.sv
// edge_overlay_key_if: pixel stream bundle for the edge-overlay keyer.
//   Pixel stream into the keyer : in_valid, line_start, frame_start, edgein
//   Pixel stream out of the keyer: out_valid, edgeout, select
//   Frame statistics             : edge_count, edge_count_last
// The master modport belongs to the source/sink side; the keyer uses slave.
interface edge_overlay_key_if #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3,
  parameter int COUNT_W  = 20
) ();
  logic                         in_valid;
  logic                         line_start;
  logic                         frame_start;
  logic [DATA_W-1:0]            edgein;
  logic                         out_valid;
  logic [CHANNELS*DATA_W-1:0]   edgeout;
  logic                         select;
  logic [COUNT_W-1:0]           edge_count;
  logic [COUNT_W-1:0]           edge_count_last;

  modport master (
    output in_valid, line_start, frame_start, edgein,
    input  out_valid, edgeout, select, edge_count, edge_count_last
  );

  modport slave (
    input  in_valid, line_start, frame_start, edgein,
    output out_valid, edgeout, select, edge_count, edge_count_last
  );
endinterface

// File: rtl/edge_overlay_key.sv
// edge_overlay_key: decides per pixel whether the edge map overrides the
// camera video (select=0 picks the overlay), builds the overlay pixel and
// counts overlay pixels per frame. Two-stage pipeline qualified by in_valid.
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   bus (slave)       : pixel stream in/out and frame counters
//   mode              : 0 exact, 1 threshold, 2 threshold+hold, 3 inverted
//   threshold         : keying threshold
//   hold_len          : extra valid pixels kept keyed after a hit in mode 2
//   color_en, color   : fixed overlay colour instead of grey replication
module edge_overlay_key #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3,
  parameter int HOLD_W   = 4,
  parameter int COUNT_W  = 20
) (
  input  logic                       clock,
  input  logic                       reset,
  edge_overlay_key_if.slave          bus,
  input  logic [1:0]                 mode,
  input  logic [DATA_W-1:0]          threshold,
  input  logic [HOLD_W-1:0]          hold_len,
  input  logic                       color_en,
  input  logic [CHANNELS*DATA_W-1:0] color
);
  localparam logic [1:0] MODE_EXACT  = 2'd0;
  localparam logic [1:0] MODE_THRESH = 2'd1;
  localparam logic [1:0] MODE_HOLD   = 2'd2;
  localparam logic [1:0] MODE_INV    = 2'd3;

  localparam logic [DATA_W-1:0]  EDGE_MAX  = '1;
  localparam logic [HOLD_W-1:0]  HC_ONE    = HOLD_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  // stage 1
  logic                       s1_valid;
  logic                       s1_line;
  logic                       s1_frame;
  logic [DATA_W-1:0]          s1_edge;
  logic [1:0]                 s1_mode;
  logic [HOLD_W-1:0]          s1_hold;
  logic                       s1_color_en;
  logic [CHANNELS*DATA_W-1:0] s1_color;
  logic                       s1_hit;

  // stage 2
  logic                       out_valid_q;
  logic [CHANNELS*DATA_W-1:0] edgeout_q;
  logic                       select_q;
  logic [COUNT_W-1:0]         count_q;
  logic [COUNT_W-1:0]         count_last_q;
  logic [HOLD_W-1:0]          hc;

  logic                       raw_hit;
  logic [HOLD_W-1:0]          hc_eff;
  logic [HOLD_W-1:0]          hc_next;
  logic                       key_next;

  always_comb begin
    raw_hit = 1'b0;
    unique case (mode)
      MODE_EXACT:            raw_hit = (bus.edgein == EDGE_MAX);
      MODE_THRESH, MODE_HOLD: raw_hit = (bus.edgein >= threshold);
      MODE_INV:              raw_hit = (bus.edgein < threshold);
      default:               raw_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_line     <= 1'b0;
      s1_frame    <= 1'b0;
      s1_edge     <= '0;
      s1_mode     <= MODE_EXACT;
      s1_hold     <= '0;
      s1_color_en <= 1'b0;
      s1_color    <= '0;
      s1_hit      <= 1'b0;
    end else begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_line     <= bus.line_start;
        s1_frame    <= bus.frame_start;
        s1_edge     <= bus.edgein;
        s1_mode     <= mode;
        s1_hold     <= hold_len;
        s1_color_en <= color_en;
        s1_color    <= color;
        s1_hit      <= raw_hit;
      end
    end
  end

  // A line boundary discards any hold carried over from the previous line
  // before this pixel is evaluated; leaving mode 2 drops it as well.
  always_comb begin
    hc_eff   = s1_line ? '0 : hc;
    key_next = s1_hit;
    hc_next  = '0;
    if (s1_mode == MODE_HOLD) begin
      if (s1_hit) begin
        key_next = 1'b1;
        hc_next  = s1_hold;
      end else if (hc_eff != '0) begin
        key_next = 1'b1;
        hc_next  = hc_eff - HC_ONE;
      end else begin
        key_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      edgeout_q    <= '0;
      select_q     <= 1'b1;
      count_q      <= '0;
      count_last_q <= '0;
      hc           <= '0;
    end else begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        hc        <= hc_next;
        select_q  <= ~key_next;
        edgeout_q <= s1_color_en ? s1_color : {CHANNELS{s1_edge}};
        if (s1_frame) begin
          // the first pixel of a new frame counts toward the new frame
          count_last_q <= count_q;
          count_q      <= key_next ? COUNT_ONE : '0;
        end else if (key_next && (count_q != COUNT_MAX)) begin
          count_q <= count_q + COUNT_ONE;
        end
      end
    end
  end

  assign bus.out_valid       = out_valid_q;
  assign bus.edgeout         = edgeout_q;
  assign bus.select          = select_q;
  assign bus.edge_count      = count_q;
  assign bus.edge_count_last = count_last_q;
endmodule

// File: tb/tb_edge_overlay_key.sv
// tb_edge_overlay_key: table-driven check of edge_overlay_key plus a few
// hand-written multi-cycle sequences (saturation, reset mid-stream, hold
// not surviving reset). A second instance with COUNT_W=3 covers saturation.
module tb_edge_overlay_key;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        in_valid, line_start, frame_start;
  logic [7:0]  edgein;
  logic [1:0]  mode;
  logic [7:0]  threshold;
  logic [3:0]  hold_len;
  logic        color_en;
  logic [23:0] color;

  edge_overlay_key_if #(.DATA_W(8), .CHANNELS(3), .COUNT_W(20)) bus ();
  edge_overlay_key_if #(.DATA_W(8), .CHANNELS(3), .COUNT_W(3))  bus_s ();

  assign bus.in_valid      = in_valid;
  assign bus.line_start    = line_start;
  assign bus.frame_start   = frame_start;
  assign bus.edgein        = edgein;
  assign bus_s.in_valid    = in_valid;
  assign bus_s.line_start  = line_start;
  assign bus_s.frame_start = frame_start;
  assign bus_s.edgein      = edgein;

  edge_overlay_key #(.DATA_W(8), .CHANNELS(3), .HOLD_W(4), .COUNT_W(20)) dut (
    .clock(clock), .reset(reset), .bus(bus), .mode(mode), .threshold(threshold),
    .hold_len(hold_len), .color_en(color_en), .color(color));

  edge_overlay_key #(.DATA_W(8), .CHANNELS(3), .HOLD_W(4), .COUNT_W(3)) dut_s (
    .clock(clock), .reset(reset), .bus(bus_s), .mode(mode), .threshold(threshold),
    .hold_len(hold_len), .color_en(color_en), .color(color));

  typedef struct {
    logic        v, ls, fs;
    logic [7:0]  px;
    logic [1:0]  md;
    logic [7:0]  thr;
    logic [3:0]  hold;
    logic        cen;
    logic [23:0] col;
    logic        e_ov, e_sel;
    logic [23:0] e_eo;
    logic [19:0] e_cnt, e_last;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  task automatic add(input logic v, ls, fs, input logic [7:0] px, input logic [1:0] md,
                     input logic [7:0] thr, input logic [3:0] hold, input logic cen,
                     input logic [23:0] col, input logic e_ov, e_sel, input logic [23:0] e_eo,
                     input logic [19:0] e_cnt, e_last);
    vec_t r;
    r.v = v; r.ls = ls; r.fs = fs; r.px = px; r.md = md; r.thr = thr; r.hold = hold;
    r.cen = cen; r.col = col; r.e_ov = e_ov; r.e_sel = e_sel; r.e_eo = e_eo;
    r.e_cnt = e_cnt; r.e_last = e_last;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_reset_state(input int idx);
    check("rst_out_valid", idx, 32'(bus.out_valid), 32'd0);
    check("rst_select", idx, 32'(bus.select), 32'd1);
    check("rst_edgeout", idx, 32'(bus.edgeout), 32'd0);
    check("rst_count", idx, 32'(bus.edge_count), 32'd0);
    check("rst_count_last", idx, 32'(bus.edge_count_last), 32'd0);
    check("rst_s_out_valid", idx, 32'(bus_s.out_valid), 32'd0);
    check("rst_s_select", idx, 32'(bus_s.select), 32'd1);
    check("rst_s_count", idx, 32'(bus_s.edge_count), 32'd0);
    check("rst_s_count_last", idx, 32'(bus_s.edge_count_last), 32'd0);
  endtask

  task automatic drive(input logic v, ls, fs, input logic [7:0] px);
    in_valid = v; line_start = ls; frame_start = fs; edgein = px;
  endtask

  initial begin
    drive(0, 0, 0, 8'h00);
    mode = 2'd0; threshold = 8'h00; hold_len = 4'd0; color_en = 1'b0; color = 24'h0;

    // each row: inputs for this cycle | outputs expected now (pixel two rows back)
    // mode 0 exact, grey
    add(1,0,0,8'hFF,0,8'h00,0,0,24'h0,      0,1,24'h000000,0,0);
    add(1,0,0,8'hFE,0,8'h00,0,0,24'h0,      0,1,24'h000000,0,0);
    add(1,0,0,8'h00,0,8'h00,0,0,24'h0,      1,0,24'hFFFFFF,1,0);
    // mode 1 threshold, fixed colour
    add(1,0,0,8'h7F,1,8'h80,0,1,24'hFF0000, 1,1,24'hFEFEFE,1,0);
    add(1,0,0,8'h80,1,8'h80,0,1,24'hFF0000, 1,1,24'h000000,1,0);
    // mode 2 hold 3, bubble after second zero
    add(1,0,0,8'hC0,2,8'h80,3,0,24'h0,      1,1,24'hFF0000,1,0);
    add(1,0,0,8'h00,2,8'h80,3,0,24'h0,      1,0,24'hFF0000,2,0);
    add(1,0,0,8'h00,2,8'h80,3,0,24'h0,      1,0,24'hC0C0C0,3,0);
    add(0,0,0,8'h55,2,8'h80,3,0,24'h0,      1,0,24'h000000,4,0);
    add(1,0,0,8'h00,2,8'h80,3,0,24'h0,      1,0,24'h000000,5,0);
    add(1,0,0,8'h00,2,8'h80,3,0,24'h0,      0,0,24'h000000,5,0);
    add(1,0,0,8'h00,2,8'h80,3,0,24'h0,      1,0,24'h000000,6,0);
    add(1,0,0,8'h00,2,8'h80,3,0,24'h0,      1,1,24'h000000,6,0);
    // hit then line_start clears hold
    add(1,0,0,8'hC0,2,8'h80,3,0,24'h0,      1,1,24'h000000,6,0);
    add(1,1,0,8'h00,2,8'h80,3,0,24'h0,      1,1,24'h000000,6,0);
    add(1,0,0,8'h00,2,8'h80,3,0,24'h0,      1,0,24'hC0C0C0,7,0);
    // hold_len 0 acts like mode 1
    add(1,0,0,8'hC0,2,8'h80,0,0,24'h0,      1,1,24'h000000,7,0);
    add(1,0,0,8'h00,2,8'h80,0,0,24'h0,      1,1,24'h000000,7,0);
    // frame roll (unkeyed), five keyed, keyed frame_start
    add(1,0,1,8'h00,1,8'h80,0,0,24'h0,      1,0,24'hC0C0C0,8,0);
    add(1,0,0,8'hFF,1,8'h80,0,0,24'h0,      1,1,24'h000000,8,0);
    add(1,0,0,8'hFF,1,8'h80,0,0,24'h0,      1,1,24'h000000,0,8);
    add(1,0,0,8'hFF,1,8'h80,0,0,24'h0,      1,0,24'hFFFFFF,1,8);
    add(1,0,0,8'hFF,1,8'h80,0,0,24'h0,      1,0,24'hFFFFFF,2,8);
    add(1,0,0,8'hFF,1,8'h80,0,0,24'h0,      1,0,24'hFFFFFF,3,8);
    add(1,0,1,8'hFF,1,8'h80,0,0,24'h0,      1,0,24'hFFFFFF,4,8);
    // mode 3 inverted
    add(1,0,0,8'h10,3,8'h80,0,0,24'h0,      1,0,24'hFFFFFF,5,8);
    add(1,0,0,8'h90,3,8'h80,0,0,24'h0,      1,0,24'hFFFFFF,1,5);
    // hold in progress cut by line_start+frame_start, then hit on line_start
    add(1,0,0,8'hC0,2,8'h80,2,0,24'h0,      1,0,24'h101010,2,5);
    add(1,1,1,8'h00,2,8'h80,2,0,24'h0,      1,1,24'h909090,2,5);
    add(1,1,0,8'hC0,2,8'h80,2,0,24'h0,      1,0,24'hC0C0C0,3,5);
    add(1,0,0,8'h00,2,8'h80,2,0,24'h0,      1,1,24'h000000,0,3);
    add(1,0,0,8'h00,2,8'h80,2,0,24'h0,      1,0,24'hC0C0C0,1,3);
    add(1,0,0,8'h00,2,8'h80,2,0,24'h0,      1,0,24'h000000,2,3);
    add(0,0,0,8'h00,2,8'h80,2,0,24'h0,      1,0,24'h000000,3,3);
    add(0,0,0,8'h00,2,8'h80,2,0,24'h0,      1,1,24'h000000,3,3);
    add(0,0,0,8'h00,2,8'h80,2,0,24'h0,      0,1,24'h000000,3,3);

    repeat (2) @(negedge clock);
    check_reset_state(-1);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clock);
      check("out_valid", i, 32'(bus.out_valid), 32'(vecs[i].e_ov));
      check("select", i, 32'(bus.select), 32'(vecs[i].e_sel));
      check("edgeout", i, 32'(bus.edgeout), 32'(vecs[i].e_eo));
      check("edge_count", i, 32'(bus.edge_count), 32'(vecs[i].e_cnt));
      check("edge_count_last", i, 32'(bus.edge_count_last), 32'(vecs[i].e_last));
      drive(vecs[i].v, vecs[i].ls, vecs[i].fs, vecs[i].px);
      mode = vecs[i].md; threshold = vecs[i].thr; hold_len = vecs[i].hold;
      color_en = vecs[i].cen; color = vecs[i].col;
    end

    // saturation: ten keyed pixels into a 3-bit counter, then reset mid-stream
    @(negedge clock);
    reset = 1'b1;
    drive(0, 0, 0, 8'h00);
    #1 check_reset_state(100);
    @(negedge clock);
    reset = 1'b0;
    mode = 2'd1; threshold = 8'h80; hold_len = 4'd0; color_en = 1'b0;
    drive(1, 0, 0, 8'hFF);
    repeat (11) @(negedge clock);
    check("sat_count_w3", 101, 32'(bus_s.edge_count), 32'd7);
    check("sat_count_w20", 101, 32'(bus.edge_count), 32'd10);
    check("sat_out_valid", 101, 32'(bus.out_valid), 32'd1);
    check("sat_select", 101, 32'(bus.select), 32'd0);
    reset = 1'b1;
    #1 check_reset_state(102);
    drive(0, 0, 0, 8'h00);

    // a hold loaded before reset must not survive it
    @(negedge clock);
    reset = 1'b0;
    mode = 2'd2; threshold = 8'h80; hold_len = 4'd15;
    drive(1, 0, 0, 8'hC0);
    @(negedge clock);
    drive(1, 0, 0, 8'h00);
    @(negedge clock);
    check("hold_pre_rst_select", 103, 32'(bus.select), 32'd0);
    reset = 1'b1;
    #2 reset = 1'b0;
    drive(1, 0, 0, 8'h00);
    @(negedge clock);
    check("rst_flush_out_valid", 104, 32'(bus.out_valid), 32'd0);
    drive(0, 0, 0, 8'h00);
    @(negedge clock);
    check("post_rst_out_valid", 105, 32'(bus.out_valid), 32'd1);
    check("post_rst_select", 105, 32'(bus.select), 32'd1);
    check("post_rst_count", 105, 32'(bus.edge_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
